// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam int unsigned FRAME_DATA_BITS = 8;
  localparam int unsigned BIT_CNT_W       = $clog2(FRAME_DATA_BITS);
  localparam logic        PS2_IDLE_LEVEL  = 1'b1;

  // A data byte plus its parity bit must carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [FRAME_DATA_BITS-1:0] d,
                                         input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_rx_sync_edge.sv
// Synchronizes the PS/2 clock/data pins and flags ps2_clk falling edges.
module ps2_sync_edge
  import ps2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic sync_data,
  output logic fall
);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   prev_clk;

  // Synchronizer chains and registered edge detect; idle level on reset avoids a false edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= {SYNC_STAGES{PS2_IDLE_LEVEL}};
      data_sync <= {SYNC_STAGES{PS2_IDLE_LEVEL}};
      prev_clk  <= PS2_IDLE_LEVEL;
      sync_data <= PS2_IDLE_LEVEL;
      fall      <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      prev_clk  <= clk_sync[SYNC_STAGES-1];
      fall      <= prev_clk & ~clk_sync[SYNC_STAGES-1];
      // Delayed alongside fall so the data bit lines up with its edge flag.
      sync_data <= data_sync[SYNC_STAGES-1];
    end
  end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: frame decode, timeout and valid/ready output register.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       busy,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned TCNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_DATA_BITS - 1);

  logic sync_data;
  logic fall;

  ps2_state_t                     state_q, state_d;
  logic [BIT_CNT_W-1:0]           bit_cnt_q, bit_cnt_d;
  logic [FRAME_DATA_BITS-1:0]     shreg_q, shreg_d;
  logic                           par_q, par_d;
  logic [TCNT_W-1:0]              tcnt_q, tcnt_d;
  logic [FRAME_DATA_BITS-1:0]     data_d;
  logic                           valid_d;
  logic                           parity_err_d;
  logic                           frame_err_d;
  logic                           overrun_d;
  logic                           good_c;
  logic                           timeout_c;

  ps2_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .sync_data(sync_data),
    .fall     (fall)
  );

  assign busy = (state_q != IDLE);

  // State, counters and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      tcnt_q     <= '0;
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      tcnt_q     <= tcnt_d;
      data       <= data_d;
      valid      <= valid_d;
      parity_err <= parity_err_d;
      frame_err  <= frame_err_d;
      overrun    <= overrun_d;
    end
  end

  // Next-state, frame checks, timeout and output-register update.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    par_d        = par_q;
    tcnt_d       = tcnt_q + TCNT_W'(1);
    data_d       = data;
    valid_d      = valid;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;
    good_c       = 1'b0;
    timeout_c    = (state_q != IDLE) && (tcnt_q == TCNT_MAX);

    if (state_q == IDLE || fall) begin
      tcnt_d = '0;
    end

    if (valid && ready) begin
      valid_d = 1'b0;
    end

    if (timeout_c) begin
      // Abort wins over a coincident edge; partial byte is discarded.
      state_d     = IDLE;
      bit_cnt_d   = '0;
      tcnt_d      = '0;
      frame_err_d = 1'b1;
    end else if (fall) begin
      case (state_q)
        IDLE: begin
          if (!sync_data) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        DATA: begin
          shreg_d = {sync_data, shreg_q[FRAME_DATA_BITS-1:1]};
          if (bit_cnt_q == LAST_BIT) begin
            state_d   = PARITY;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
        PARITY: begin
          par_d   = sync_data;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!sync_data) begin
            frame_err_d = 1'b1;
          end else if (!odd_parity_ok(shreg_q, par_q)) begin
            parity_err_d = 1'b1;
          end else begin
            good_c = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (good_c) begin
      if (!valid || ready) begin
        data_d  = shreg_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_rx.sv
// Scoreboard bench for ps2_rx: frame-level model pushes expectations, a monitor pops and compares.
module tb_ps2_rx;

  localparam int unsigned SYNC = 2;
  localparam int unsigned TO   = 200;
  localparam int EV_PAR = 1;
  localparam int EV_FRM = 2;
  localparam int EV_OVR = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       busy;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  int         ev_q[$];

  ps2_rx #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .data(data), .valid(valid), .ready(ready), .busy(busy),
    .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pops expectations whenever the DUT consumes a byte or raises a pulse.
  task automatic monitor();
    int code;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (parity_err || frame_err || overrun) begin
          code = parity_err ? EV_PAR : (frame_err ? EV_FRM : EV_OVR);
          chk("pulse_one_hot", 32'($countones({parity_err, frame_err, overrun})), 32'd1);
          if (ev_q.size() == 0) chk("unexpected_pulse", 32'(code), 32'd0);
          else chk("pulse_type", 32'(code), 32'(ev_q.pop_front()));
        end
        if (valid && ready) begin
          if (exp_q.size() == 0) chk("unexpected_byte", 32'(data), 32'hFFFF);
          else chk("byte", 32'(data), 32'(exp_q.pop_front()));
        end
      end
    end
  endtask

  task automatic send_bit(input logic b, input int half);
    ps2_data = b;
    tick(half);
    ps2_clk = 1'b0;
    tick(half);
    ps2_clk = 1'b1;
  endtask

  // Model decides the frame outcome from the framing rules, then the frame is driven.
  task automatic send_frame(input logic [7:0] b, input bit flip_par, input logic stop,
                            input int half, input bit hs_at_end);
    logic par;
    par = ((($countones(b) + 1) % 2) == 1) ^ flip_par;  // odd parity: ones(b)+par odd
    if (!stop) ev_q.push_back(EV_FRM);
    else if ((($countones(b) + int'(par)) % 2) == 0) ev_q.push_back(EV_PAR);
    else if (exp_q.size() == 0 || ready || hs_at_end) exp_q.push_back(b);
    else ev_q.push_back(EV_OVR);

    send_bit(1'b0, half);
    for (int i = 0; i < 8; i++) send_bit(b[i], half);
    send_bit(par, half);
    if (hs_at_end) begin
      ps2_data = stop;
      tick(half);
      ps2_clk = 1'b0;
      tick(SYNC + 1);
      ready = 1'b1;
      tick(1);
      ready = 1'b0;
      tick(half - int'(SYNC) - 2);
      ps2_clk = 1'b1;
    end else begin
      send_bit(stop, half);
    end
    ps2_data = 1'b1;
    tick(half);
  endtask

  initial begin
    fork
      monitor();
    join_none

    rst = 1'b1; ready = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
    tick(4);
    chk("rst_data", 32'(data), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_pulses", 32'({parity_err, frame_err, overrun}), 32'h0);
    rst = 1'b0;
    tick(4);
    chk("idle_busy", 32'(busy), 32'h0);

    // Clean 0x1C with ready held high.
    ready = 1'b1;
    send_frame(8'h1C, 1'b0, 1'b1, 40, 1'b0);
    chk("good_data_hold", 32'(data), 32'h1C);
    chk("good_valid_clear", 32'(valid), 32'h0);

    // Same byte with parity flipped.
    send_frame(8'h1C, 1'b1, 1'b1, 40, 1'b0);
    chk("par_valid", 32'(valid), 32'h0);
    chk("par_data", 32'(data), 32'h1C);

    // Lone fall with data high in IDLE is a bad start bit.
    ev_q.push_back(EV_FRM);
    send_bit(1'b1, 20);
    tick(10);
    chk("badstart_busy", 32'(busy), 32'h0);

    // Timeout after start + 3 data bits, then a clean 0xAA.
    ev_q.push_back(EV_FRM);
    send_bit(1'b0, 40);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 40);
    chk("partial_busy", 32'(busy), 32'h1);
    ps2_data = 1'b1;
    tick(int'(TO) + 20);
    chk("timeout_busy", 32'(busy), 32'h0);
    send_frame(8'hAA, 1'b0, 1'b1, 40, 1'b0);

    // Overrun: second byte dropped while first is pending.
    ready = 1'b0;
    send_frame(8'h1C, 1'b0, 1'b1, 40, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b1, 40, 1'b0);
    chk("ovr_data", 32'(data), 32'h1C);
    chk("ovr_valid", 32'(valid), 32'h1);
    ready = 1'b1;
    tick(1);
    chk("ovr_drain_valid", 32'(valid), 32'h0);
    ready = 1'b0;

    // Handshake in the exact completion cycle of the next frame.
    send_frame(8'h1C, 1'b0, 1'b1, 40, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b1, 40, 1'b1);
    chk("simul_data", 32'(data), 32'h5A);
    chk("simul_valid", 32'(valid), 32'h1);
    ready = 1'b1;
    tick(1);
    chk("simul_drain_valid", 32'(valid), 32'h0);
    ready = 1'b0;

    // Reset mid-frame with a pending byte.
    send_frame(8'h33, 1'b0, 1'b1, 40, 1'b0);
    send_bit(1'b0, 40);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 40);
    chk("mid_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    tick(1);
    chk("rst_mid_busy", 32'(busy), 32'h0);
    chk("rst_mid_valid", 32'(valid), 32'h0);
    exp_q.delete();
    rst = 1'b0;
    ps2_data = 1'b1;
    tick(10);
    ready = 1'b1;
    send_frame(8'h1C, 1'b0, 1'b1, 40, 1'b0);

    // Randomized frames: byte, parity corruption, stop corruption, bit rate.
    for (int n = 0; n < 24; n++) begin
      send_frame(8'($urandom_range(255)), ($urandom_range(3) == 0),
                 ($urandom_range(6) != 0), int'($urandom_range(40, 6)), 1'b0);
    end

    tick(50);
    chk("bytes_outstanding", 32'(exp_q.size()), 32'd0);
    chk("pulses_outstanding", 32'(ev_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
